// File: rtl/rom_arbiter_if.sv
// Bundle of the fetch/load request-response ports and the shared ROM lookup
// seen by rom_arbiter; slave is the arbiter side, master the client side.
interface rom_arbiter_if #(
  parameter int IDX_LEN  = 32,
  parameter int DATA_LEN = 32
);
  logic                if_req_valid_i;
  logic [IDX_LEN-1:0]  if_req_idx_i;
  logic                if_req_ready_o;
  logic                if_rsp_valid_o;
  logic [DATA_LEN-1:0] if_rsp_data_o;
  logic                if_rsp_ready_i;

  logic                ls_req_valid_i;
  logic [IDX_LEN-1:0]  ls_req_idx_i;
  logic                ls_req_ready_o;
  logic                ls_rsp_valid_o;
  logic [DATA_LEN-1:0] ls_rsp_data_o;
  logic                ls_rsp_ready_i;

  logic [IDX_LEN-1:0]  rom_idx_o;
  logic [DATA_LEN-1:0] rom_data_i;

  modport slave (
    input  if_req_valid_i, if_req_idx_i, if_rsp_ready_i,
    input  ls_req_valid_i, ls_req_idx_i, ls_rsp_ready_i,
    input  rom_data_i,
    output if_req_ready_o, if_rsp_valid_o, if_rsp_data_o,
    output ls_req_ready_o, ls_rsp_valid_o, ls_rsp_data_o,
    output rom_idx_o
  );

  modport master (
    output if_req_valid_i, if_req_idx_i, if_rsp_ready_i,
    output ls_req_valid_i, ls_req_idx_i, ls_rsp_ready_i,
    output rom_data_i,
    input  if_req_ready_o, if_rsp_valid_o, if_rsp_data_o,
    input  ls_req_ready_o, ls_rsp_valid_o, ls_rsp_data_o,
    input  rom_idx_o
  );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin sharing of one combinational ROM between the fetch and load
// ports, each with a one-entry response buffer.
`ifndef CPU_PC_SIZE
`define CPU_PC_SIZE 32
`endif
`ifndef CPU_INSTR_SIZE
`define CPU_INSTR_SIZE 32
`endif

module rom_arbiter #(
  parameter int IDX_LEN  = `CPU_PC_SIZE,
  parameter int DATA_LEN = `CPU_INSTR_SIZE
) (
  input  logic          clk,
  input  logic          rst,
  rom_arbiter_if.slave  bus
);

  localparam logic [0:0] GRANT_IF = 1'b0;
  localparam logic [0:0] GRANT_LS = 1'b1;

  logic                last_grant_q, last_grant_d;
  logic                if_valid_q, if_valid_d;
  logic                ls_valid_q, ls_valid_d;
  logic [DATA_LEN-1:0] if_data_q, if_data_d;
  logic [DATA_LEN-1:0] ls_data_q, ls_data_d;

  logic                if_drain, ls_drain;
  logic                if_elig, ls_elig;
  logic                grant_if, grant_ls;
  logic [IDX_LEN-1:0]  rom_idx;

  // Outputs are forced low for the whole reset cycle, not just after the edge.
  assign bus.if_rsp_valid_o = if_valid_q & ~rst;
  assign bus.ls_rsp_valid_o = ls_valid_q & ~rst;
  assign bus.if_rsp_data_o  = rst ? '0 : if_data_q;
  assign bus.ls_rsp_data_o  = rst ? '0 : ls_data_q;
  assign bus.if_req_ready_o = grant_if;
  assign bus.ls_req_ready_o = grant_ls;
  assign bus.rom_idx_o      = rom_idx;

  always_comb begin
    if_drain = bus.if_rsp_valid_o & bus.if_rsp_ready_i;
    ls_drain = bus.ls_rsp_valid_o & bus.ls_rsp_ready_i;
    if_elig  = ~rst & bus.if_req_valid_i & (~if_valid_q | if_drain);
    ls_elig  = ~rst & bus.ls_req_valid_i & (~ls_valid_q | ls_drain);

    // On a tie the port that did not win last time gets the ROM.
    grant_if = if_elig & (~ls_elig | (last_grant_q == GRANT_LS));
    grant_ls = ls_elig & ~grant_if;

    rom_idx  = grant_ls ? bus.ls_req_idx_i : bus.if_req_idx_i;

    last_grant_d = last_grant_q;
    if (grant_if) last_grant_d = GRANT_IF;
    if (grant_ls) last_grant_d = GRANT_LS;

    if_valid_d = if_valid_q;
    if_data_d  = if_data_q;
    if (if_drain) if_valid_d = 1'b0;
    if (grant_if) begin
      if_valid_d = 1'b1;
      if_data_d  = bus.rom_data_i;
    end

    ls_valid_d = ls_valid_q;
    ls_data_d  = ls_data_q;
    if (ls_drain) ls_valid_d = 1'b0;
    if (grant_ls) begin
      ls_valid_d = 1'b1;
      ls_data_d  = bus.rom_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GRANT_LS;
      if_valid_q   <= 1'b0;
      ls_valid_q   <= 1'b0;
      if_data_q    <= '0;
      ls_data_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      if_valid_q   <= if_valid_d;
      ls_valid_q   <= ls_valid_d;
      if_data_q    <= if_data_d;
      ls_data_q    <= ls_data_d;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: accepted requests push expected ROM words,
// a separate monitor pops and compares responses per port.
module tb_rom_arbiter;
  localparam int IDX  = 32;
  localparam int DATA = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rom_arbiter_if #(.IDX_LEN(IDX), .DATA_LEN(DATA)) bus ();

  rom_arbiter #(.IDX_LEN(IDX), .DATA_LEN(DATA)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [DATA-1:0] rom_mem [256];
  assign bus.rom_data_i = rom_mem[bus.rom_idx_o[9:2]];

  int compared   = 0;
  int mismatched = 0;

  logic [DATA-1:0] if_q [$];
  logic [DATA-1:0] ls_q [$];
  bit if_occ, ls_occ, last_ls;
  int if_rdy_cnt = 0;
  int ls_rdy_cnt = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit r,
                               input bit ifv, input logic [IDX-1:0] ifi, input bit ifr,
                               input bit lsv, input logic [IDX-1:0] lsi, input bit lsr);
    rst                = r;
    bus.if_req_valid_i = ifv;
    bus.if_req_idx_i   = ifi;
    bus.if_rsp_ready_i = ifr;
    bus.ls_req_valid_i = lsv;
    bus.ls_req_idx_i   = lsi;
    bus.ls_rsp_ready_i = lsr;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [IDX-1:0] randIdx();
    return 32'h8000_0000 + (IDX'($urandom_range(0, 255)) << 2);
  endfunction

  // Request side: reference model of eligibility, round-robin and buffer occupancy.
  always @(negedge clk) begin
    bit eif, els, gif, gls;
    logic [IDX-1:0] exp_idx;
    if (rst) begin
      checkOutput("rst_if_req_ready", bus.if_req_ready_o, 0);
      checkOutput("rst_ls_req_ready", bus.ls_req_ready_o, 0);
      checkOutput("rst_if_rsp_valid", bus.if_rsp_valid_o, 0);
      checkOutput("rst_ls_rsp_valid", bus.ls_rsp_valid_o, 0);
      checkOutput("rst_if_rsp_data", bus.if_rsp_data_o, 0);
      checkOutput("rst_ls_rsp_data", bus.ls_rsp_data_o, 0);
      if_q.delete();
      ls_q.delete();
      if_occ  = 0;
      ls_occ  = 0;
      last_ls = 1;
    end else begin
      if_rdy_cnt += int'(bus.if_req_ready_o);
      ls_rdy_cnt += int'(bus.ls_req_ready_o);
      checkOutput("if_rsp_valid", bus.if_rsp_valid_o, if_occ);
      checkOutput("ls_rsp_valid", bus.ls_rsp_valid_o, ls_occ);
      eif = bus.if_req_valid_i && (!if_occ || bus.if_rsp_ready_i);
      els = bus.ls_req_valid_i && (!ls_occ || bus.ls_rsp_ready_i);
      gif = eif && (!els || last_ls);
      gls = els && !gif;
      checkOutput("if_req_ready", bus.if_req_ready_o, gif);
      checkOutput("ls_req_ready", bus.ls_req_ready_o, gls);
      exp_idx = gls ? bus.ls_req_idx_i : bus.if_req_idx_i;
      checkOutput("rom_idx", bus.rom_idx_o, exp_idx);
      if (if_occ && bus.if_rsp_ready_i) if_occ = 0;
      if (ls_occ && bus.ls_rsp_ready_i) ls_occ = 0;
      if (gif) begin
        if_occ  = 1;
        last_ls = 0;
        if_q.push_back(rom_mem[bus.if_req_idx_i[9:2]]);
      end
      if (gls) begin
        ls_occ  = 1;
        last_ls = 1;
        ls_q.push_back(rom_mem[bus.ls_req_idx_i[9:2]]);
      end
    end
  end

  // Response side: every presented word must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.if_rsp_valid_o) begin
        if (if_q.size() == 0) checkOutput("if_rsp_unexpected", 1, 0);
        else begin
          checkOutput("if_rsp_data", bus.if_rsp_data_o, if_q[0]);
          if (bus.if_rsp_ready_i) void'(if_q.pop_front());
        end
      end
      if (bus.ls_rsp_valid_o) begin
        if (ls_q.size() == 0) checkOutput("ls_rsp_unexpected", 1, 0);
        else begin
          checkOutput("ls_rsp_data", bus.ls_rsp_data_o, ls_q[0]);
          if (bus.ls_rsp_ready_i) void'(ls_q.pop_front());
        end
      end
    end
  end

  initial begin
    int base_if, base_ls;
    logic [IDX-1:0] step_idx;
    for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;

    applyStimulus(1, 0, '0, 0, 0, '0, 0);
    applyStimulus(1, 0, '0, 0, 0, '0, 0);

    // Tie on the first cycle out of reset, then alternation.
    applyStimulus(0, 1, 32'h8000_0000, 1, 1, 32'h8000_0004, 1);
    applyStimulus(0, 1, 32'h8000_0000, 1, 1, 32'h8000_0004, 1);
    applyStimulus(0, 0, '0, 1, 0, '0, 1);
    applyStimulus(0, 0, '0, 1, 0, '0, 1);

    base_if = if_rdy_cnt;
    base_ls = ls_rdy_cnt;
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, randIdx(), 1, 1, randIdx(), 1);
    checkOutput("alt_if_grants", if_rdy_cnt - base_if, 4);
    checkOutput("alt_ls_grants", ls_rdy_cnt - base_ls, 4);
    applyStimulus(0, 0, '0, 1, 0, '0, 1);

    // Single-port streaming.
    base_if = if_rdy_cnt;
    step_idx = 32'h8000_0000;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, step_idx, 1, 0, '0, 1);
      step_idx += 4;
    end
    checkOutput("stream_if_grants", if_rdy_cnt - base_if, 8);
    applyStimulus(0, 0, '0, 1, 0, '0, 1);

    // Stalled fetch consumer while load keeps flowing.
    applyStimulus(0, 1, randIdx(), 0, 0, '0, 1);
    base_ls = ls_rdy_cnt;
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, randIdx(), 0, 1, randIdx(), 1);
    checkOutput("stall_ls_grants", ls_rdy_cnt - base_ls, 3);
    applyStimulus(0, 0, '0, 1, 0, '0, 1);
    applyStimulus(0, 0, '0, 1, 0, '0, 1);

    // Reset with both buffers full, then a tie.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, randIdx(), 0, 1, randIdx(), 0);
    applyStimulus(1, 1, randIdx(), 0, 1, randIdx(), 0);
    base_if = if_rdy_cnt;
    applyStimulus(0, 1, randIdx(), 1, 1, randIdx(), 1);
    checkOutput("post_rst_if_first", if_rdy_cnt - base_if, 1);

    // Random stress with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 9) < 7), randIdx(), ($urandom_range(0, 9) < 6),
                    ($urandom_range(0, 9) < 7), randIdx(), ($urandom_range(0, 9) < 6));
    end

    for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, 1, 0, '0, 1);
    checkOutput("if_q_empty", if_q.size(), 0);
    checkOutput("ls_q_empty", ls_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
